coin_acceptor: RTL
==================

# coin_acceptor

Front-end stage that feeds the drink machine's `coin[1:0]` input. It conditions two raw, asynchronous coin-slot sensors (half-unit and one-unit) by synchronizing, debouncing and edge-detecting them. It queues accepted coins in a 4-entry FIFO and presents them to the drink machine as single-cycle coin codes separated by a guaranteed idle gap. Ambiguous or overflowing insertions are flagged, not forwarded.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized cycles required to change a filtered sensor level; range 1..1023.
- `GAP_CYCLES`, 2: cycles of `coin=2'b00` forced after every emitted code; range 1..255; 0 is illegal.
- `clk`  in  1  single system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sense_half`  in  1  raw half-unit slot sensor, asynchronous, may bounce.
- `sense_one`  in  1  raw one-unit slot sensor, asynchronous, may bounce.
- `coin`  out  2  to drink machine: 2'b01 half unit, 2'b10 one unit, 2'b00 none; 2'b11 never driven.
- `coin_err`  out  1  one-cycle pulse on rejected insertion (simultaneous coins or FIFO overflow).
- `pending`  out  3  current FIFO occupancy, 0..4.

## Operation
- Synchronizer: 2-flop chain per sensor; reset value 0.
- Debounce, per line: counter of width clog2(DEBOUNCE_CYCLES+1) and a filtered level.
  - Counter increments while the synchronized level differs from the filtered level.
  - Counter clears when the levels match.
  - When the counter reaches DEBOUNCE_CYCLES, the filtered level takes the synchronized value and the counter clears.
- Edge detect: event = filtered rising edge (filtered & ~filtered_d). Falling edges produce nothing.
- Event resolution:
  - Half event only: push 2'b01.
  - One event only: push 2'b10.
  - Both events in the same cycle: push nothing; pulse `coin_err`.
- FIFO: depth 4, 2-bit entries, order preserved.
  - A push when full and no pop in that cycle drops the entry and pulses `coin_err`.
  - A push and pop in the same cycle are both honoured, including when full. `pending` is unchanged in that case.
- Emit FSM, states IDLE / EMIT / GAP:
  - IDLE: if the FIFO is non-empty, pop and register the code onto `coin`, then go to EMIT. Otherwise `coin=00`.
  - EMIT: `coin` holds the code for exactly one cycle, then the FSM loads the gap counter with GAP_CYCLES and goes to GAP with `coin=00`.
  - GAP: `coin=00`; decrement the gap counter each cycle; on reaching 0 go to IDLE.
- Minimum spacing between two codes is therefore 1+GAP_CYCLES cycles of 00. The drink machine never sees the same coin on two adjacent cycles.
- Reset (async, at any time, including mid-EMIT or mid-GAP):
  - `coin=00`, `coin_err=0`, `pending=0`.
  - FIFO emptied, FSM in IDLE, filtered levels 0, all counters 0.
  - Queued coins are discarded.
  - A sensor already high at reset release is treated as a new insertion after debounce.

## Timing
- All outputs are registered; no combinational path from the sensors to outputs.
- Latency: with a sensor stably high from edge E0 (the first edge that samples it high), `coin` goes valid in the cycle after edge E0+DEBOUNCE_CYCLES+4, provided the FIFO was empty and the FSM was in IDLE. Breakdown:
  - Synchronizer: 2 edges.
  - Debounce: DEBOUNCE_CYCLES edges.
  - FIFO write: 1 edge.
  - Pop and drive: 1 edge.
- `coin_err` asserts in the cycle after the rejecting edge, for exactly one cycle.
- `pending` updates on the same edge as the push or pop.

## Test plan
- Reset: drive `rst_n=0` with both sensors toggling -> `coin=00`, `coin_err=0`, `pending=0` throughout; nothing emitted for DEBOUNCE_CYCLES+4 cycles after release with sensors low.
- Clean coin (DEBOUNCE_CYCLES=16): `sense_half` high for 40 cycles, then low -> exactly one `coin=01` pulse, valid after edge E0+20; the release produces no pulse.
- Bounce and glitch: `sense_one` high for 15 cycles, then low -> no output. Then toggle it every 5 cycles for 50 cycles and hold it high -> exactly one `coin=10`, 20 edges after the final rising transition.
- Overflow (GAP_CYCLES=255): six half coins, each 20 cycles high / 20 cycles low:
  - Coin 1 is emitted.
  - Coins 2–5 queue, bringing `pending` to 4.
  - Coin 6 pulses `coin_err` and `pending` stays 4.
  - Four further `01` pulses follow, 256 cycles apart; `pending` counts down to 0.
- Simultaneous: both sensors rise on the same cycle and stay high for 30 cycles -> one `coin_err` pulse, `coin` stays 00, `pending` stays 0.
- Reset mid-operation: queue a `10` and a `01`, then assert `rst_n` during GAP -> `coin=00` and `pending=0` immediately; no codes appear after release.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin-slot front end: sync, debounce and edge-detect two sensors,
// queue coins in a 4-deep FIFO and emit spaced one-cycle codes.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sense_half,
  input  logic       sense_one,
  output logic [1:0] coin,
  output logic       coin_err,
  output logic [2:0] pending
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [7:0] GAP_LD = 8'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  logic [1:0]    sync1, sync2, filt, filt_d;
  logic [CW-1:0] db_cnt [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      filt   <= '0;
      filt_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1  <= {sense_one, sense_half};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [1:0] rise;
  logic       push, both;
  logic [1:0] push_code;

  assign rise      = filt & ~filt_d;
  assign push      = rise[0] ^ rise[1];
  assign both      = &rise;
  assign push_code = rise[1] ? 2'b10 : 2'b01;

  logic [1:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       full, empty, pop, wr_en;
  logic       err_q;

  assign full  = (count == 3'd4);
  assign empty = (count == 3'd0);
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      err_q <= both | (push & full & ~pop);
    end
  end

  state_t     state, state_n;
  logic [7:0] gap, gap_n;
  logic [1:0] coin_q, coin_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gap    <= '0;
      coin_q <= '0;
    end else begin
      state  <= state_n;
      gap    <= gap_n;
      coin_q <= coin_n;
    end
  end

  always_comb begin
    state_n = state;
    gap_n   = gap;
    coin_n  = 2'b00;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          coin_n  = mem[rd_ptr];
          state_n = EMIT;
        end
      end
      EMIT: begin
        gap_n   = GAP_LD;
        state_n = GAP;
      end
      GAP: begin
        gap_n = gap - 8'd1;
        if (gap <= 8'd1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign coin     = coin_q;
  assign coin_err = err_q;
  assign pending  = count;

endmodule
